// File: rtl/antenna_select.sv
// antenna_select: accumulates per-antenna |h|^2 over a window of WIN_LEN SSR
// snapshots, scans the accumulators one per cycle for the strongest antenna,
// and hands the winner to the RF switch controller.
//
// Handshakes (both ports): a beat transfers on a rising edge where valid and
// ready are both 1. The producer holds data stable while valid is high and
// ready is low. ssr_ready depends only on state and rst_n, never on ssr_valid.
// sel_valid depends only on state, never on sel_ready.
module antenna_select #(
    parameter int DATA_WIDTH = 32,
    parameter int ANTENA_NUM = 4,
    parameter int WIN_LEN    = 16,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(WIN_LEN) + 1,
    parameter int IDX_WIDTH  = $clog2(ANTENA_NUM)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              ssr_valid,
    output logic                              ssr_ready,
    input  logic [2*ANTENA_NUM*DATA_WIDTH-1:0] ssr,
    output logic                              sel_valid,
    input  logic                              sel_ready,
    output logic [IDX_WIDTH-1:0]              sel_idx,
    output logic [ANTENA_NUM-1:0]             sel_onehot,
    output logic [ACC_WIDTH-1:0]              sel_power
);

    localparam int LANE_W = 2*DATA_WIDTH;
    localparam int CNT_W  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

    // DONE is the single cycle that registers the scan winner onto the outputs.
    typedef enum logic [1:0] {ST_ACC, ST_SCAN, ST_DONE, ST_OUT} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [ACC_WIDTH-1:0]   acc [ANTENA_NUM];
    logic [CNT_W-1:0]       cnt;
    logic [IDX_WIDTH-1:0]   k;
    logic [ACC_WIDTH-1:0]   best;
    logic [IDX_WIDTH-1:0]   best_idx;
    logic                   ssr_xfer;
    logic                   last_beat;
    logic                   last_k;

    assign ssr_xfer  = ssr_valid && ssr_ready;
    assign last_beat = (cnt == CNT_W'(WIN_LEN - 1));
    assign last_k    = (k == IDX_WIDTH'(ANTENA_NUM - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_ACC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        ssr_ready = 1'b0;
        sel_valid = 1'b0;
        case (state)
            ST_ACC: begin
                ssr_ready = rst_n;
                if (ssr_xfer && last_beat) begin
                    state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (last_k) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_OUT;
            end
            ST_OUT: begin
                sel_valid = 1'b1;
                if (sel_ready) begin
                    state_nxt = ST_ACC;
                end
            end
            default: begin
                state_nxt = ST_ACC;
            end
        endcase
    end

    // Datapath: accumulate, sequential max scan, result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ANTENA_NUM; i++) begin
                acc[i] <= '0;
            end
            cnt        <= '0;
            k          <= '0;
            best       <= '0;
            best_idx   <= '0;
            sel_idx    <= '0;
            sel_onehot <= '0;
            sel_power  <= '0;
        end else begin
            case (state)
                ST_ACC: begin
                    k <= '0;
                    if (ssr_xfer) begin
                        for (int i = 0; i < ANTENA_NUM; i++) begin
                            acc[i] <= acc[i] + ACC_WIDTH'(ssr[i*LANE_W +: LANE_W]);
                        end
                        cnt <= last_beat ? '0 : cnt + 1'b1;
                    end
                end
                ST_SCAN: begin
                    // Strict greater-than keeps the lowest index on ties.
                    if (k == '0) begin
                        best     <= acc[0];
                        best_idx <= '0;
                    end else if (acc[k] > best) begin
                        best     <= acc[k];
                        best_idx <= k;
                    end
                    k <= last_k ? '0 : k + 1'b1;
                end
                ST_DONE: begin
                    sel_idx    <= best_idx;
                    sel_power  <= best;
                    sel_onehot <= ANTENA_NUM'(1) << best_idx;
                end
                ST_OUT: begin
                    if (sel_ready) begin
                        for (int i = 0; i < ANTENA_NUM; i++) begin
                            acc[i] <= '0;
                        end
                    end
                end
                default: begin
                    k <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_antenna_select.sv
// Bench for antenna_select: reset, table-driven constant windows with latency
// check, tie/zero/max windows, backpressure, gapped random input, and a
// mid-window reset. Results are checked through an expected queue.
module tb_antenna_select;

  localparam int DW    = 32;
  localparam int N     = 4;
  localparam int WL    = 16;
  localparam int AW    = 2*DW + $clog2(WL) + 1;
  localparam int IW    = $clog2(N);
  localparam int LW    = 2*DW;
  localparam int SSR_W = 2*N*DW;
  localparam int RW    = IW + N + AW;

  logic             clk;
  logic             rst_n;
  logic             ssr_valid;
  logic             ssr_ready;
  logic [SSR_W-1:0] ssr;
  logic             sel_valid;
  logic             sel_ready;
  logic [IW-1:0]    sel_idx;
  logic [N-1:0]     sel_onehot;
  logic [AW-1:0]    sel_power;

  int total = 0;
  int bad   = 0;
  logic [RW-1:0] exp_q[$];
  logic [AW-1:0] msum [N];

  typedef struct {
    logic [SSR_W-1:0] vec;
    logic [IW-1:0]    idx;
    logic [N-1:0]     oh;
    logic [AW-1:0]    pw;
  } vec_t;

  vec_t tbl[6];

  antenna_select #(
    .DATA_WIDTH(DW),
    .ANTENA_NUM(N),
    .WIN_LEN(WL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ssr_valid(ssr_valid),
    .ssr_ready(ssr_ready),
    .ssr(ssr),
    .sel_valid(sel_valid),
    .sel_ready(sel_ready),
    .sel_idx(sel_idx),
    .sel_onehot(sel_onehot),
    .sel_power(sel_power)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [SSR_W-1:0] pack4(input logic [LW-1:0] l0, input logic [LW-1:0] l1,
                                             input logic [LW-1:0] l2, input logic [LW-1:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // driver: offer one beat, wait until it transfers, return at the next negedge
  task automatic send_beat(input logic [SSR_W-1:0] v);
    int budget = 200;
    ssr       = v;
    ssr_valid = 1'b1;
    while (!ssr_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check("beat_timeout", 1, 0);
    @(negedge clk);
    ssr_valid = 1'b0;
    for (int i = 0; i < N; i++) msum[i] += AW'(v[i*LW +: LW]);
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) msum[i] = '0;
  endtask

  // reference winner over msum: strictly greater replaces, so lowest index wins ties
  task automatic push_model();
    logic [AW-1:0] b;
    logic [IW-1:0] bi;
    b  = msum[0];
    bi = '0;
    for (int i = 1; i < N; i++) begin
      if (msum[i] > b) begin
        b  = msum[i];
        bi = IW'(i);
      end
    end
    exp_q.push_back({bi, N'(1) << bi, b});
  endtask

  task automatic wait_drain();
    int budget = 100;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("drain", exp_q.size(), 0);
  endtask

  // scoreboard: sample just before the edge where a result handshake happens
  always @(negedge clk) begin
    logic [RW-1:0] e;
    #4;
    if (rst_n && sel_valid && sel_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sel_idx",    sel_idx,    e[RW-1 -: IW]);
        check("sel_onehot", sel_onehot, e[AW +: N]);
        check("sel_power",  sel_power,  e[AW-1:0]);
      end
    end
  end

  initial begin
    logic [SSR_W-1:0] junk;

    tbl[0] = '{pack4(10, 20, 30, 5),   2'd2, 4'b0100, 69'd480};
    tbl[1] = '{pack4(7, 9, 9, 1),      2'd1, 4'b0010, 69'd144};
    tbl[2] = '{pack4(0, 0, 0, 0),      2'd0, 4'b0001, 69'd0};
    tbl[3] = '{{SSR_W{1'b1}},          2'd0, 4'b0001, 69'h0_FFFF_FFFF_FFFF_FFFF_0};
    tbl[4] = '{pack4(3, 3, 3, 900),    2'd3, 4'b1000, 69'd14400};
    tbl[5] = '{pack4(0, 77, 0, 76),    2'd1, 4'b0010, 69'd1232};

    // reset with ssr_valid asserted
    rst_n     = 1'b0;
    ssr_valid = 1'b1;
    ssr       = {8{$urandom}};
    sel_ready = 1'b0;
    clear_model();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_ssr_ready",  ssr_ready,  0);
      check("rst_sel_valid",  sel_valid,  0);
      check("rst_sel_idx",    sel_idx,    0);
      check("rst_sel_onehot", sel_onehot, 0);
      check("rst_sel_power",  sel_power,  0);
    end
    rst_n     = 1'b1;
    ssr_valid = 1'b0;
    sel_ready = 1'b1;
    @(negedge clk);
    check("post_rst_ssr_ready", ssr_ready, 1);
    check("post_rst_sel_valid", sel_valid, 0);

    // table-driven windows with latency check
    for (int t = 0; t < 6; t++) begin
      exp_q.push_back({tbl[t].idx, tbl[t].oh, tbl[t].pw});
      for (int b = 0; b < WL; b++) send_beat(tbl[t].vec);
      for (int c = 0; c < N + 1; c++) begin
        check("latency_low", sel_valid, 0);
        @(negedge clk);
      end
      check("latency_high", sel_valid, 1);
      wait_drain();
    end
    clear_model();

    // backpressure: result held, upstream stalled, offered beat joins next window
    sel_ready = 1'b0;
    for (int b = 0; b < WL; b++) send_beat(pack4(1, 2, 3, 4));
    exp_q.push_back({2'd3, 4'b1000, 69'd64});
    junk      = pack4(50, 0, 0, 0);
    ssr       = junk;
    ssr_valid = 1'b1;
    for (int c = 0; c < 20 && !sel_valid; c++) @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      check("bp_sel_valid", sel_valid,  1);
      check("bp_ssr_ready", ssr_ready,  0);
      check("bp_sel_idx",   sel_idx,    3);
      check("bp_onehot",    sel_onehot, 4'b1000);
      check("bp_power",     sel_power,  64);
      @(negedge clk);
    end
    sel_ready = 1'b1;
    @(negedge clk);
    check("hold_sel_valid", sel_valid, 0);
    check("hold_sel_idx",   sel_idx,   3);
    check("hold_sel_power", sel_power, 64);
    check("drain_bp", exp_q.size(), 0);
    clear_model();
    send_beat(junk);
    for (int b = 1; b < WL; b++) send_beat(pack4(1, 1, 1, 1));
    exp_q.push_back({2'd0, 4'b0001, 69'd65});
    wait_drain();

    // gapped random input with random result backpressure
    for (int w = 0; w < 2; w++) begin
      clear_model();
      for (int b = 0; b < WL; b++) begin
        ssr_valid = 1'b0;
        ssr       = {8{$urandom}};
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send_beat({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      end
      push_model();
      sel_ready = 1'b0;
      repeat ($urandom_range(6, 12)) @(negedge clk);
      sel_ready = 1'b1;
      wait_drain();
    end

    // mid-window reset: only post-reset beats count
    clear_model();
    for (int b = 0; b < 8; b++) send_beat(pack4(0, 0, 0, 1000));
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("mid_rst_power",  sel_power,  0);
      check("mid_rst_onehot", sel_onehot, 0);
      check("mid_rst_ready",  ssr_ready,  0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int b = 0; b < WL; b++) send_beat(pack4(5, 6, 7, 8));
    exp_q.push_back({2'd3, 4'b1000, 69'd128});
    wait_drain();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
